// File: rtl/clk_gen_tune_ctrl.sv
// Successive-approximation trim of a tunable clock generator: each trial code is
// settled, the oscillator edges are counted over a window, and the trial bit is kept or dropped.
module clk_gen_tune_ctrl #(
   parameter int CODE_W = 5,
   parameter int CNT_W  = 16,
   parameter int SETTLE = 8
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              start_in,
   input  logic              abort_in,
   input  logic [CNT_W-1:0]  target_in,
   input  logic [CNT_W-1:0]  window_in,
   input  logic              osc_edge_in,
   output logic [CODE_W-1:0] tune_code_out,
   output logic              busy_out,
   output logic              done_out,
   output logic [CNT_W-1:0]  last_count_out
);

   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int TMR_W = (CNT_W > 8) ? CNT_W : 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_DECIDE,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   edge_q, edge_d;
   logic [CNT_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   target_q, target_d;
   logic [CNT_W-1:0]   win_q, win_d;

   logic [TMR_W-1:0]   win_last;
   logic [IDX_W-1:0]   idx_m1;

   // A zero-length window is stretched to a single measurement cycle.
   assign win_last = (win_q == '0) ? '0 : TMR_W'(win_q - 1'b1);
   assign idx_m1   = idx_q - 1'b1;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      idx_d    = idx_q;
      tmr_d    = tmr_q;
      edge_d   = edge_q;
      last_d   = last_q;
      target_d = target_q;
      win_d    = win_q;

      if (abort_in && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_in && !abort_in) begin
                  target_d           = target_in;
                  win_d              = window_in;
                  code_d             = '0;
                  code_d[CODE_W-1]   = 1'b1;
                  idx_d              = IDX_W'(CODE_W - 1);
                  tmr_d              = '0;
                  state_d            = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (tmr_q == TMR_W'(SETTLE - 1)) begin
                  tmr_d   = '0;
                  edge_d  = '0;
                  state_d = ST_MEASURE;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            ST_MEASURE: begin
               if (osc_edge_in && edge_q != {CNT_W{1'b1}}) edge_d = edge_q + 1'b1;
               if (tmr_q == win_last) begin
                  tmr_d   = '0;
                  state_d = ST_DECIDE;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            ST_DECIDE: begin
               last_d = edge_q;
               // Still too fast only when strictly above target; equality drops the bit.
               if (!(edge_q > target_q)) code_d[idx_q] = 1'b0;
               if (idx_q != '0) begin
                  code_d[idx_m1] = 1'b1;
                  idx_d          = idx_m1;
                  state_d        = ST_SETTLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         idx_q    <= IDX_W'(CODE_W - 1);
         tmr_q    <= '0;
         edge_q   <= '0;
         last_q   <= '0;
         target_q <= '0;
         win_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         idx_q    <= idx_d;
         tmr_q    <= tmr_d;
         edge_q   <= edge_d;
         last_q   <= last_d;
         target_q <= target_d;
         win_q    <= win_d;
      end
   end

   assign tune_code_out  = code_q;
   assign last_count_out = last_q;
   assign busy_out       = (state_q != ST_IDLE);
   assign done_out       = (state_q == ST_DONE);

endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
// Scoreboarded bench for clk_gen_tune_ctrl: a periodic oscillator model feeds edges,
// an arithmetic SAR model predicts each run's outcome, a monitor checks run ends.
module tb_clk_gen_tune_ctrl;

   localparam int CODE_W = 5;
   localparam int CNT_W  = 16;
   localparam int SETTLE = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  target;
   logic [CNT_W-1:0]  window;
   logic              osc;
   logic [CODE_W-1:0] code;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  last;

   clk_gen_tune_ctrl #(.CODE_W(CODE_W), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
      .clk_in(clk), .reset_in(rst), .start_in(start), .abort_in(abort),
      .target_in(target), .window_in(window), .osc_edge_in(osc),
      .tune_code_out(code), .busy_out(busy), .done_out(done), .last_count_out(last)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit with_done;
      int code;
      int last;
      int cycles;   // -1: duration not checked
   } exp_t;
   exp_t sb[$];

   // Oscillator model: pulses on the first m(code) cycles of every osc_d-cycle period,
   // so any osc_d consecutive cycles hold exactly m(code) edges whatever the phase.
   int osc_mode = 2;   // 0 periodic, 1 held high, 2 held low
   int osc_a = 0, osc_b = 0, osc_d = 1;
   int t = 0;
   int m_cur;

   function automatic int dens(int c);
      int m;
      m = osc_a - osc_b * c;
      if (m < 0) m = 0;
      if (m > osc_d) m = osc_d;
      return m;
   endfunction

   always_comb begin
      m_cur = osc_a - osc_b * int'(code);
      if (m_cur < 0) m_cur = 0;
      if (m_cur > osc_d) m_cur = osc_d;
   end

   always @(posedge clk) t <= (t + 1 >= osc_d) ? 0 : t + 1;

   assign osc = (osc_mode == 1) ? 1'b1 : (osc_mode == 2) ? 1'b0 : (t < m_cur);

   function automatic int count_for(int c, int win);
      int w;
      w = (win == 0) ? 1 : win;
      if (osc_mode == 1) return w;
      if (osc_mode == 2) return 0;
      return dens(c) * (w / osc_d);
   endfunction

   function automatic exp_t sar_model(int tgt, int win);
      exp_t e;
      int c, trial, cnt;
      c = 0;
      e.last = 0;
      for (int i = CODE_W - 1; i >= 0; i--) begin
         trial  = c | (1 << i);
         cnt    = count_for(trial, win);
         e.last = cnt;
         if (cnt > tgt) c = trial;
      end
      e.with_done = 1'b1;
      e.code      = c;
      e.cycles    = CODE_W * (SETTLE + ((win == 0) ? 1 : win) + 1) + 1;
      return e;
   endfunction

   task automatic chk(string name, int act, int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: observes run ends (done pulse, or busy dropping without done).
   bit mon_prev_busy = 1'b0;
   bit mon_saw_done  = 1'b0;
   int mon_cyc       = 0;

   always @(negedge clk) begin
      exp_t e;
      if (busy) mon_cyc++;
      if (done) begin
         if (mon_saw_done) chk("done_single_pulse", 2, 1);
         if (sb.size() == 0) chk("sb_has_entry_done", 0, 1);
         else begin
            e = sb.pop_front();
            chk("end_kind_done", 1, int'(e.with_done));
            chk("final_code", int'(code), e.code);
            chk("final_last_count", int'(last), e.last);
            if (e.cycles >= 0) chk("run_length", mon_cyc, e.cycles);
         end
         mon_saw_done = 1'b1;
      end
      if (mon_prev_busy && !busy) begin
         if (!mon_saw_done) begin
            if (sb.size() == 0) chk("sb_has_entry_stop", 0, 1);
            else begin
               e = sb.pop_front();
               chk("end_kind_stop", 0, int'(e.with_done));
               chk("stop_code", int'(code), e.code);
               chk("stop_last_count", int'(last), e.last);
            end
         end
         mon_cyc      = 0;
         mon_saw_done = 1'b0;
      end
      mon_prev_busy = busy;
   end

   task automatic wait_idle(int limit, string name);
      int i;
      i = 0;
      while (busy && i < limit) begin
         @(negedge clk);
         i++;
      end
      if (busy) chk(name, 1, 0);
   endtask

   // Issue one run and scramble target/window right after acceptance.
   task automatic launch(int tgt, int win);
      @(negedge clk);
      target = CNT_W'(tgt);
      window = CNT_W'(win);
      start  = 1'b1;
      sb.push_back(sar_model(tgt, win));
      @(negedge clk);
      start  = 1'b0;
      target = CNT_W'($urandom);
      window = CNT_W'($urandom);
   endtask

   task automatic full_run(int tgt, int win);
      launch(tgt, win);
      wait_idle(CODE_W * (SETTLE + win + 2) + 50, "run_timeout");
   endtask

   task automatic nominal_osc();
      osc_mode = 0; osc_a = 200; osc_b = 4; osc_d = 250;
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; start = 1'b0; abort = 1'b0; target = '0; window = '0;
      repeat (3) @(negedge clk);
      chk("reset_code", int'(code), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_last", int'(last), 0);
      rst = 1'b0;

      // start together with abort in IDLE is refused
      @(negedge clk);
      start = 1'b1; abort = 1'b1; target = 16'd5; window = 16'd5;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_with_abort_refused", int'(busy), 0);

      // Nominal SAR; 250-cycle window so the 200-4*code edge density fits in single-cycle pulses
      nominal_osc();
      full_run(140, 250);
      chk("nominal_code", int'(code), 14);
      chk("nominal_last", int'(last), 140);

      repeat (4) @(negedge clk);
      chk("idle_hold_code", int'(code), 14);
      chk("idle_hold_last", int'(last), 140);

      osc_mode = 1;
      full_run(0, 100);
      chk("held_high_code", int'(code), 31);
      osc_mode = 2;
      full_run(0, 100);
      chk("held_low_code", int'(code), 0);
      chk("held_low_last", int'(last), 0);

      osc_mode = 1;
      full_run(0, 0);
      chk("win0_code", int'(code), 31);
      chk("win0_last", int'(last), 1);

      // Abort inside the third measurement window (busy cycles 527..776)
      nominal_osc();
      @(negedge clk);
      target = 16'd140; window = 16'd250; start = 1'b1;
      e.with_done = 1'b0; e.code = 12; e.last = 168; e.cycles = -1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (599) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_code", int'(code), 12);

      // Reset in the middle of SETTLE
      @(negedge clk);
      target = 16'd140; window = 16'd250; start = 1'b1;
      e.with_done = 1'b0; e.code = 0; e.last = 0; e.cycles = -1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_reset_code", int'(code), 0);
      chk("midrun_reset_busy", int'(busy), 0);
      chk("midrun_reset_done", int'(done), 0);
      chk("midrun_reset_last", int'(last), 0);

      // Start pulsed while busy is ignored; run ends once with unchanged timing
      launch(140, 250);
      repeat (4) @(negedge clk);
      target = 16'd0; window = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(2000, "busy_start_timeout");
      repeat (10) @(negedge clk);
      chk("no_second_run", int'(busy), 0);

      // Randomized runs
      for (int k = 0; k < 25; k++) begin
         int sel, win;
         sel = int'($urandom_range(0, 5));
         if (sel < 4) begin
            osc_mode = 0;
            osc_d    = int'($urandom_range(10, 60));
            osc_a    = int'($urandom_range(osc_d / 2, osc_d));
            osc_b    = int'($urandom_range(0, 3));
            win      = osc_d;
         end else begin
            osc_mode = (sel == 4) ? 1 : 2;
            win      = int'($urandom_range(0, 30));
         end
         full_run(int'($urandom_range(0, 60)), win);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
